// File: rtl/arith_pkg.sv
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared types and elaboration helpers for the chunked adders.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A single-chunk configuration still needs a one-bit index.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_chunk_adder.sv
// ============================================================================
// Module   : ripple_chunk_adder
// Purpose  : Combinational WIDTH-bit unsigned ripple adder with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_chunk_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/chunked_zext_adder.sv
// ============================================================================
// Module   : chunked_zext_adder
// Purpose  : Multi-cycle Sum = A + zext(B), CHUNK bits per clock, valid/ready.
//            Define CHUNK_ADDER_EARLY_EXIT_EN to finish once no carry and no
//            further B bits remain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_zext_adder
    import arith_pkg::*;
#(
    parameter int A_WIDTH = 41,
    parameter int B_WIDTH = 15,
    parameter int CHUNK   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   Sum
);

    localparam int c_nchunk = ceil_div(A_WIDTH, CHUNK);
    localparam int c_pad_w  = c_nchunk * CHUNK;
    localparam int c_idx_w  = idx_width(c_nchunk);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

    if (B_WIDTH > A_WIDTH) begin : g_width_check
        $error("chunked_zext_adder: B_WIDTH must not exceed A_WIDTH");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [c_pad_w-1:0]   r_a;
    logic [c_pad_w-1:0]   r_b;
    logic [c_pad_w:0]     r_sum;
    logic [c_pad_w:0]     w_sum_next;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic [CHUNK-1:0]     w_a_chunk;
    logic [CHUNK-1:0]     w_b_chunk;
    logic [CHUNK-1:0]     w_chunk_sum;
    logic                 w_cout;
    logic                 w_last;
    logic                 w_early;
    logic                 w_accept;
    logic                 w_unused;
    int unsigned          w_base;

    assign w_base    = 32'(r_idx) * CHUNK;
    assign w_a_chunk = CHUNK'(r_a >> w_base);
    assign w_b_chunk = CHUNK'(r_b >> w_base);
    assign w_last    = (r_idx == c_last_idx);
    assign w_accept  = in_valid && in_ready;

    ripple_chunk_adder #(
        .WIDTH (CHUNK)
    ) u_chunk_adder (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_chunk_sum),
        .cout (w_cout)
    );

`ifdef CHUNK_ADDER_EARLY_EXIT_EN
    logic w_b_hi_zero;

    // Nothing left to add once the carry dies and B has no higher bits.
    always_comb begin
        w_b_hi_zero = 1'b1;
        for (int j = 0; j < c_nchunk; j++) begin
            if ((j > int'(r_idx)) && (r_b[j*CHUNK +: CHUNK] != '0)) begin
                w_b_hi_zero = 1'b0;
            end
        end
        w_early = (r_state == ST_ADD) && !w_cout && w_b_hi_zero;
    end
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_sum_next = r_sum;
        for (int j = 0; j < c_nchunk; j++) begin
            if (j == int'(r_idx)) begin
                w_sum_next[j*CHUNK +: CHUNK] = w_chunk_sum;
            end else if (w_early && (j > int'(r_idx))) begin
                w_sum_next[j*CHUNK +: CHUNK] = r_a[j*CHUNK +: CHUNK];
            end
        end
        // Top bit of the padded result holds the final carry when no pad exists.
        if (w_last) begin
            w_sum_next[c_pad_w] = w_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= c_pad_w'(A);
            r_b     <= c_pad_w'(B);
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == ST_ADD) begin
            r_sum   <= w_sum_next;
            r_carry <= w_cout;
            r_idx   <= r_idx + c_idx_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)             w_state_next = ST_ADD;
            ST_ADD:  if (w_last || w_early)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready)            w_state_next = ST_IDLE;
            default:                           w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    assign Sum      = r_sum[A_WIDTH:0];
    assign w_unused = ^r_sum;

endmodule

`default_nettype wire
